axi_reg_bank: RTL
=================

AXI_REG_BANK -- requirements
Module: axi_reg_bank

Interface
REQ-001 SHALL have parameter NUM_REGS, default 8, number of 32-bit registers (2..64).
REQ-002 SHALL have parameter ADDR_W, default 5, AXI address width, at least clog2(NUM_REGS)+2.
REQ-003 SHALL have parameter RO_MASK, default 0, bit n=1 makes register n read-only (value taken from hw_in).
REQ-004 SHALL have parameter W1C_MASK, default 0, bit n=1 makes register n a sticky status register (hardware set, write-1-to-clear).
REQ-005 SHALL have parameter RST_VAL, default 0, NUM_REGS*32-bit flat reset image for RW registers.
REQ-006 Ports: ACLK  in  1  sole clock; ARESETN  in  1  asynchronous active-low reset.
REQ-007 Ports: AWADDR in ADDR_W, AWVALID in 1, AWREADY out 1, AWPROT in 3 (ignored).
REQ-008 Ports: WDATA in 32, WSTRB in 4, WVALID in 1, WREADY out 1, BRESP out 2, BVALID out 1, BREADY in 1.
REQ-009 Ports: ARADDR in ADDR_W, ARVALID in 1, ARREADY out 1, ARPROT in 3 (ignored), RDATA out 32, RRESP out 2, RVALID out 1, RREADY in 1.
REQ-010 Ports: reg_q out NUM_REGS*32 flat register contents; wr_pulse out NUM_REGS one-cycle write strobe per register.
REQ-011 Ports: hw_in in NUM_REGS*32 values for RO registers; hw_set in NUM_REGS*32 per-bit set for W1C registers.

Function
REQ-012 Write channel SHALL latch AW and W independently: AWREADY high while no address is held, WREADY high while no data is held.
REQ-013 Write SHALL commit in the cycle after both address and data are held; BVALID rises the same cycle and holds until BREADY.
REQ-014 No new AW or W SHALL be accepted while BVALID is high; maximum one outstanding write.
REQ-015 Register index = addr[ADDR_W-1:2]; addr[1:0] ignored.
REQ-016 RW register commit: byte k updated from WDATA[8k+7:8k] only when WSTRB[k]=1.
REQ-017 W1C register commit: bits with WDATA=1 and strobe enabled clear; hw_set has priority over clear in the same cycle.
REQ-018 W1C bits SHALL set on any cycle hw_set bit is 1, independent of bus activity.
REQ-019 Write to RO register or to index >= NUM_REGS SHALL change nothing, and BRESP = 2'b10 (SLVERR); otherwise BRESP = 2'b00.
REQ-020 wr_pulse[n] SHALL pulse one cycle, on the commit cycle, for successful writes only.
REQ-021 ARREADY SHALL be high while RVALID is low; on AR handshake, RDATA/RRESP register and RVALID rises the next cycle, held until RREADY.
REQ-022 Read of RO register returns hw_in sampled at AR handshake; index >= NUM_REGS returns 0 with RRESP = 2'b10.
REQ-023 Read and write channels SHALL operate concurrently; a read in the commit cycle of the same register returns the pre-commit value.
REQ-024 reg_q for RO entries SHALL mirror hw_in combinationally.

Reset
REQ-025 ARESETN low SHALL asynchronously clear AWREADY, WREADY, BVALID, ARREADY, RVALID, BRESP, RRESP, RDATA, wr_pulse, held flags.
REQ-026 RW registers reset to RST_VAL slice; W1C registers reset to 0.
REQ-027 Ready outputs SHALL assert in the first ACLK edge after ARESETN deasserts; transactions in flight at reset are discarded.

Structure
REQ-028 Shared package axi_reg_pkg SHALL hold RESP_OKAY/RESP_SLVERR constants and reg_kind_t enum {RW, RO, W1C}.
REQ-029 Per-register update logic SHALL be one sub-module axi_reg_cell (kind parameter, 32-bit, strobe, hw_set), instantiated NUM_REGS times.

Verification
REQ-030 Write 0x00000001..0x00000004 to addrs 0x0,0x4,0x8,0xC, read back -> identical data, BRESP/RRESP OKAY.
REQ-031 Reg2=0xAABBCCDD, write 0x11223344 WSTRB=4'b0101 -> read 0xAA22CC44, wr_pulse[2] one cycle.
REQ-032 W1C reg5: hw_set=0x0000000F one cycle, write 0x00000003 -> read 0x0000000C; simultaneous set 0x1 and clear 0x1 -> bit0 stays 1.
REQ-033 Write addr 0x1C with NUM_REGS=4 and write to RO reg -> BRESP SLVERR, reg_q unchanged; read 0x1C -> RDATA 0, SLVERR.
REQ-034 W presented 3 cycles before AW, BREADY held low 4 cycles -> single commit, BVALID stable, no second AW accepted.
REQ-035 ARESETN pulled low mid-write (AW held, W pending) -> BVALID 0, registers equal RST_VAL, next write completes normally.

Source files
------------

// File: rtl/axi_reg_pkg.sv
// Shared constants and types for the AXI4-Lite register bank.
package axi_reg_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    RW  = 2'd0,
    RO  = 2'd1,
    W1C = 2'd2
  } reg_kind_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
  } wr_beat_t;

  // Read-only wins over sticky when both mask bits are set.
  function automatic reg_kind_t kind_of(input logic ro, input logic w1c);
    if (ro) return RO;
    if (w1c) return W1C;
    return RW;
  endfunction

endpackage

// File: rtl/axi_reg_cell.sv
// One 32-bit register: byte-strobed RW, hw-mirrored RO, or sticky W1C status.
module axi_reg_cell
  import axi_reg_pkg::*;
#(
  parameter reg_kind_t         KIND = RW,
  parameter logic [DATA_W-1:0] RST  = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [STRB_W-1:0] i_wstrb,
  input  logic [DATA_W-1:0] i_hw_in,
  input  logic [DATA_W-1:0] i_hw_set,
  output logic [DATA_W-1:0] o_q
);

  localparam logic [DATA_W-1:0] RST_EFF = (KIND == W1C) ? '0 : RST;

  logic [DATA_W-1:0] r_q;
  logic [DATA_W-1:0] w_mask;
  logic [DATA_W-1:0] w_next;

  // Sticky bits: hardware set outranks a software clear in the same cycle.
  always_comb begin
    w_mask = '0;
    for (int k = 0; k < int'(STRB_W); k++) begin
      w_mask[8*k +: 8] = {8{i_we & i_wstrb[k]}};
    end
    w_next = (r_q & ~w_mask) | (i_wdata & w_mask);
    if (KIND == W1C) begin
      w_next = (r_q & ~(i_wdata & w_mask)) | i_hw_set;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_q <= RST_EFF;
    else        r_q <= w_next;
  end

  assign o_q = (KIND == RO) ? i_hw_in : r_q;

endmodule

// File: rtl/axi_reg_bank.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit registers with RW/RO/W1C behaviour.
module axi_reg_bank
  import axi_reg_pkg::*;
#(
  parameter int unsigned                   NUM_REGS = 8,
  parameter int unsigned                   ADDR_W   = 5,
  parameter logic [NUM_REGS-1:0]           RO_MASK  = '0,
  parameter logic [NUM_REGS-1:0]           W1C_MASK = '0,
  parameter logic [NUM_REGS*DATA_W-1:0]    RST_VAL  = '0
) (
  input  logic                         ACLK,
  input  logic                         ARESETN,
  input  logic [ADDR_W-1:0]            AWADDR,
  input  logic                         AWVALID,
  output logic                         AWREADY,
  input  logic [2:0]                   AWPROT,
  input  logic [DATA_W-1:0]            WDATA,
  input  logic [STRB_W-1:0]            WSTRB,
  input  logic                         WVALID,
  output logic                         WREADY,
  output logic [1:0]                   BRESP,
  output logic                         BVALID,
  input  logic                         BREADY,
  input  logic [ADDR_W-1:0]            ARADDR,
  input  logic                         ARVALID,
  output logic                         ARREADY,
  input  logic [2:0]                   ARPROT,
  output logic [DATA_W-1:0]            RDATA,
  output logic [1:0]                   RRESP,
  output logic                         RVALID,
  input  logic                         RREADY,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q,
  output logic [NUM_REGS-1:0]          wr_pulse,
  input  logic [NUM_REGS*DATA_W-1:0]   hw_in,
  input  logic [NUM_REGS*DATA_W-1:0]   hw_set
);

  localparam int unsigned IDX_W = ADDR_W - 2;

  logic                r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
  logic                r_aw_held, r_w_held;
  logic [1:0]          r_bresp, r_rresp;
  logic [DATA_W-1:0]   r_rdata;
  logic [NUM_REGS-1:0] r_wr_pulse;
  logic [IDX_W-1:0]    r_aw_idx;
  wr_beat_t            r_w_beat;

  logic                w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_wr_ok, w_rd_ok;
  logic                w_aw_held_n, w_w_held_n, w_bvalid_n, w_rvalid_n;
  logic [NUM_REGS-1:0] w_wsel, w_rsel, w_we;
  logic [DATA_W-1:0]   w_rd_mux;
  logic                w_unused;

  assign w_unused = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0]};

  // Handshakes, address decode, and next state of both channels.
  always_comb begin
    w_aw_hs     = AWVALID & r_awready;
    w_w_hs      = WVALID & r_wready;
    w_ar_hs     = ARVALID & r_arready;
    w_commit    = r_aw_held & r_w_held;
    w_wsel      = '0;
    w_rsel      = '0;
    w_rd_mux    = '0;
    for (int n = 0; n < int'(NUM_REGS); n++) begin
      w_wsel[n] = (r_aw_idx == IDX_W'(n));
      w_rsel[n] = (ARADDR[ADDR_W-1:2] == IDX_W'(n));
      if (w_rsel[n]) w_rd_mux = w_rd_mux | reg_q[n*DATA_W +: DATA_W];
    end
    w_wr_ok     = |(w_wsel & ~RO_MASK);
    w_rd_ok     = |w_rsel;
    w_we        = w_commit ? (w_wsel & ~RO_MASK) : '0;
    w_aw_held_n = r_aw_held | w_aw_hs;
    w_w_held_n  = r_w_held | w_w_hs;
    w_bvalid_n  = r_bvalid & ~BREADY;
    if (w_commit) begin
      w_aw_held_n = 1'b0;
      w_w_held_n  = 1'b0;
      w_bvalid_n  = 1'b1;
    end
    w_rvalid_n  = w_ar_hs | (r_rvalid & ~RREADY);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_aw_held  <= 1'b0;
      r_w_held   <= 1'b0;
      r_bresp    <= RESP_OKAY;
      r_rresp    <= RESP_OKAY;
      r_rdata    <= '0;
      r_wr_pulse <= '0;
      r_aw_idx   <= '0;
      r_w_beat   <= '0;
    end else begin
      r_aw_held  <= w_aw_held_n;
      r_w_held   <= w_w_held_n;
      r_bvalid   <= w_bvalid_n;
      r_awready  <= ~w_aw_held_n & ~w_bvalid_n;
      r_wready   <= ~w_w_held_n & ~w_bvalid_n;
      r_wr_pulse <= w_we;
      r_rvalid   <= w_rvalid_n;
      r_arready  <= ~w_rvalid_n;
      if (w_aw_hs)  r_aw_idx <= AWADDR[ADDR_W-1:2];
      if (w_w_hs)   r_w_beat <= '{data: WDATA, strb: WSTRB};
      if (w_commit) r_bresp  <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
      if (w_ar_hs) begin
        r_rdata <= w_rd_mux;
        r_rresp <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  for (genvar n = 0; n < int'(NUM_REGS); n++) begin : g_reg
    axi_reg_cell #(
      .KIND (kind_of(RO_MASK[n], W1C_MASK[n])),
      .RST  (RST_VAL[n*DATA_W +: DATA_W])
    ) u_cell (
      .clk      (ACLK),
      .rst_n    (ARESETN),
      .i_we     (w_we[n]),
      .i_wdata  (r_w_beat.data),
      .i_wstrb  (r_w_beat.strb),
      .i_hw_in  (hw_in[n*DATA_W +: DATA_W]),
      .i_hw_set (hw_set[n*DATA_W +: DATA_W]),
      .o_q      (reg_q[n*DATA_W +: DATA_W])
    );
  end

  assign AWREADY  = r_awready;
  assign WREADY   = r_wready;
  assign BVALID   = r_bvalid;
  assign BRESP    = r_bresp;
  assign ARREADY  = r_arready;
  assign RVALID   = r_rvalid;
  assign RDATA    = r_rdata;
  assign RRESP    = r_rresp;
  assign wr_pulse = r_wr_pulse;

endmodule
